// File: rtl/mc10181_seq.sv
// Nibble-serial 36-bit ALU sequencer driving one external mc10181 slice.
// The operation runs from nibble 8 (bits 32:35) to nibble 0 (bits 0:3), rippling the carry through a register.
module mc10181_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [0:3]  op_s,
   input  logic        op_boole,
   input  logic        op_cin,
   input  logic [0:35] op_a,
   input  logic [0:35] op_b,
   output logic [0:3]  sl_s,
   output logic        sl_boole,
   output logic        sl_cin,
   output logic [0:3]  sl_a,
   output logic [0:3]  sl_b,
   input  logic [0:3]  sl_f,
   input  logic        sl_cout,
   input  logic        sl_cg,
   input  logic        sl_cp,
   output logic        busy,
   output logic        done,
   output logic [0:35] result,
   output logic        carry_out
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [0:3]  s_q, s_d;
   logic        boole_q, boole_d;
   logic [0:35] a_q, a_d;
   logic [0:35] b_q, b_d;
   logic [0:35] result_q, result_d;
   logic        carry_q, carry_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Group propagate/generate are not needed for a single ripple slice.
   logic unused_slice;
   assign unused_slice = sl_cg ^ sl_cp;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      boole_d  = boole_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      case (state_q)
         IDLE: begin
            // abort on the same edge as start drops the request
            if (start && !abort) begin
               s_d      = op_s;
               boole_d  = op_boole;
               a_d      = op_a;
               b_d      = op_b;
               carry_d  = op_cin;
               cnt_d    = 4'd8;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               cnt_d   = 4'd8;
               state_d = IDLE;
            end else begin
               for (int n = 0; n < 9; n++)
                  if (cnt_q == 4'(n)) result_d[4*n +: 4] = sl_f;
               carry_d = sl_cout;
               if (cnt_q == 4'd0) begin
                  cnt_d   = 4'd8;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd8;
         s_q      <= '0;
         boole_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         boole_q  <= boole_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Outside RUN the slice sees a quiet, fixed function.
   always_comb begin
      sl_s     = 4'b0000;
      sl_boole = 1'b1;
      sl_cin   = 1'b0;
      sl_a     = 4'b0000;
      sl_b     = 4'b0000;
      if (state_q == RUN) begin
         sl_s     = s_q;
         sl_boole = boole_q;
         sl_cin   = carry_q;
         for (int n = 0; n < 9; n++) begin
            if (cnt_q == 4'(n)) begin
               sl_a = a_q[4*n +: 4];
               sl_b = b_q[4*n +: 4];
            end
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_mc10181_seq.sv
// Directed bench for mc10181_seq with a behavioural mc10181 slice closing the loop.
module tb_mc10181_seq;

   logic        clk, reset_n, start, abort, op_boole, op_cin;
   logic [0:3]  op_s;
   logic [0:35] op_a, op_b;
   logic [0:3]  sl_s, sl_a, sl_b, sl_f;
   logic        sl_boole, sl_cin, sl_cout, sl_cg, sl_cp;
   logic        busy, done, carry_out;
   logic [0:35] result;

   int n_cmp = 0;
   int n_err = 0;

   mc10181_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .op_s(op_s), .op_boole(op_boole), .op_cin(op_cin), .op_a(op_a), .op_b(op_b),
      .sl_s(sl_s), .sl_boole(sl_boole), .sl_cin(sl_cin), .sl_a(sl_a), .sl_b(sl_b),
      .sl_f(sl_f), .sl_cout(sl_cout), .sl_cg(sl_cg), .sl_cp(sl_cp),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mc10181 slice: F = X plus Y plus Cin (arith) or F = ~(X ^ Y) (logic)
   logic [3:0] m_a, m_b, m_x, m_y;
   logic [4:0] m_sum;
   always_comb begin
      m_a   = sl_a;
      m_b   = sl_b;
      m_x   = m_a | (m_b & {4{sl_s[0]}}) | (~m_b & {4{sl_s[1]}});
      m_y   = (m_a & ~m_b & {4{sl_s[2]}}) | (m_a & m_b & {4{sl_s[3]}});
      m_sum = {1'b0, m_x} + {1'b0, m_y} + {4'b0, sl_cin};
      sl_f  = sl_boole ? ~(m_x ^ m_y) : m_sum[3:0];
      sl_cout = m_sum[4];
      sl_cg = ~m_sum[4];
      sl_cp = 1'b0;
   end

   // Accepts the operation at edge k; returns at the sample point of cycle k+1.
   task automatic launch(input logic [0:3] s, input logic bl, input logic ci,
                         input logic [0:35] a, input logic [0:35] b);
      @(negedge clk);
      op_s = s; op_boole = bl; op_cin = ci; op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 0; abort = 0; op_s = 4'b0101; op_boole = 0; op_cin = 1;
      op_a = 36'o777777777777; op_b = 36'o777777777777;
      #1;
      n_cmp++; if ({busy, done, carry_out} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, carry_out}); end
      n_cmp++; if (result !== 36'o0) begin n_err++; $display("FAIL reset_result: got %o want 0", result); end
      n_cmp++; if ({sl_s, sl_boole, sl_cin, sl_a, sl_b} !== 14'b0000_1_0_0000_0000) begin n_err++;
         $display("FAIL reset_slice: got %b want 00001000000000", {sl_s, sl_boole, sl_cin, sl_a, sl_b}); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add;
      int first = 0, nd = 0, nb = 0;
      logic [0:35] r = '0;
      logic co = 1'b0;
      launch(4'b1001, 1'b0, 1'b0, 36'o000000000001, 36'o000000000001);
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) @(negedge clk);
         if (busy) nb++;
         if (done) begin nd++; if (first == 0) begin first = c; r = result; co = carry_out; end end
      end
      n_cmp++; if (first !== 10) begin n_err++; $display("FAIL add_latency: got %0d want 10", first); end
      n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL add_done_count: got %0d want 1", nd); end
      n_cmp++; if (nb !== 9) begin n_err++; $display("FAIL add_busy_cycles: got %0d want 9", nb); end
      n_cmp++; if (r !== 36'o000000000002) begin n_err++; $display("FAIL add_result: got %o want 000000000002", r); end
      n_cmp++; if (co !== 1'b0) begin n_err++; $display("FAIL add_carry: got %b want 0", co); end
   endtask

   task automatic test_carry_wrap;
      logic [0:35] r = '1;
      logic co = 1'b0;
      launch(4'b1001, 1'b0, 1'b0, 36'o777777777777, 36'o000000000001);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         if (c <= 9) begin
            n_cmp++;
            if (sl_cin !== (c >= 2)) begin n_err++; $display("FAIL wrap_sl_cin_c%0d: got %b want %b", c, sl_cin, c >= 2); end
         end
         if (done) begin r = result; co = carry_out; end
      end
      n_cmp++; if (r !== 36'o0) begin n_err++; $display("FAIL wrap_result: got %o want 0", r); end
      n_cmp++; if (co !== 1'b1) begin n_err++; $display("FAIL wrap_carry: got %b want 1", co); end
   endtask

   task automatic test_not_a;
      logic [0:35] r = '0;
      launch(4'b0000, 1'b1, 1'b0, 36'o123456701234, 36'o777777777777);
      n_cmp++; if ({sl_boole, sl_a, sl_b} !== 9'b1_1100_1111) begin n_err++;
         $display("FAIL nota_first_nibble: got %b want 111001111", {sl_boole, sl_a, sl_b}); end
      for (int c = 2; c <= 12; c++) begin
         @(negedge clk);
         if (done) r = result;
      end
      n_cmp++; if (r !== 36'o654321076543) begin n_err++; $display("FAIL nota_result: got %o want 654321076543", r); end
   endtask

   task automatic test_back_to_back;
      int nd = 0, d1 = 0, d2 = 0;
      logic [0:35] r1 = '0, r2 = '0;
      launch(4'b1001, 1'b0, 1'b0, 36'o000000000001, 36'o000000000001);
      for (int c = 1; c <= 24; c++) begin
         if (c > 1) @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) begin d1 = c; r1 = result; end else begin d2 = c; r2 = result; end
         end
         start = (c == 3 || c == 10 || c == 11);
         if (c == 3) op_a = 36'o000000007777;
         if (c == 11) begin op_a = 36'o000000000005; op_b = 36'o000000000003; end
      end
      start = 1'b0;
      n_cmp++; if (nd !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
      n_cmp++; if (d1 !== 10 || d2 !== 21) begin n_err++; $display("FAIL b2b_done_cycles: got %0d,%0d want 10,21", d1, d2); end
      n_cmp++; if (r1 !== 36'o2) begin n_err++; $display("FAIL b2b_result1: got %o want 2", r1); end
      n_cmp++; if (r2 !== 36'o10) begin n_err++; $display("FAIL b2b_result2: got %o want 10", r2); end
   endtask

   task automatic test_abort;
      int nd = 0;
      logic b5 = 1'b0, b6 = 1'b1;
      launch(4'b1001, 1'b0, 1'b0, 36'o111111111111, 36'o222222222222);
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) @(negedge clk);
         if (done) nd++;
         if (c == 5) b5 = busy;
         if (c == 6) b6 = busy;
         abort = (c == 5);
      end
      n_cmp++; if (b5 !== 1'b1 || b6 !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b%b want 10", b5, b6); end
      n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", nd); end
      n_cmp++; if (result !== 36'o000000133333) begin n_err++; $display("FAIL abort_partial: got %o want 000000133333", result); end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_cmp++; if (busy !== 1'b0 || result !== 36'o000000133333) begin n_err++;
         $display("FAIL abort_vs_start: got busy=%b result=%o want busy=0 result=000000133333", busy, result); end
   endtask

   task automatic test_reset_mid_run;
      int nd = 0, first = 0;
      logic [0:35] r = '0;
      launch(4'b1001, 1'b0, 1'b0, 36'o000000000001, 36'o000000000001);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({busy, done, carry_out} !== 3'b000 || result !== 36'o0) begin n_err++;
         $display("FAIL rst_run_outputs: got flags=%b result=%o want 000 0", {busy, done, carry_out}, result); end
      n_cmp++; if ({sl_s, sl_boole, sl_cin, sl_a, sl_b} !== 14'b0000_1_0_0000_0000) begin n_err++;
         $display("FAIL rst_run_slice: got %b want 00001000000000", {sl_s, sl_boole, sl_cin, sl_a, sl_b}); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL rst_run_ghost: got %0d active cycles want 0", nd); end
      launch(4'b1001, 1'b0, 1'b0, 36'o000000000001, 36'o000000000001);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         if (done && first == 0) begin first = c; r = result; end
      end
      n_cmp++; if (first !== 10 || r !== 36'o2) begin n_err++;
         $display("FAIL rst_run_restart: got cycle %0d result %o want 10 2", first, r); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_carry_wrap;
      test_not_a;
      test_back_to_back;
      test_abort;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc10181_seq.md
MC10181_SEQ -- requirements
Module: mc10181_seq

Interface
REQ-001 Parameters: none; operand width fixed at 36 bits (PDP-10 numbering [0:35], bit 0 MSB), nine 4-bit nibbles.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 abort  input  1  terminate current operation, return to IDLE.
REQ-006 op_s  input  [0:3]  mc10181 function select for the whole operation.
REQ-007 op_boole  input  1  mc10181 boolean-mode select (1=logic, 0=arithmetic).
REQ-008 op_cin  input  1  carry into least-significant nibble.
REQ-009 op_a, op_b  input  [0:35] each  operands.
REQ-010 sl_s  output  [0:3]; sl_boole  output  1; sl_cin  output  1; sl_a, sl_b  output  [0:3] each  drive to one external mc10181 slice.
REQ-011 sl_f  input  [0:3]; sl_cout  input  1  slice result and carry out; sl_cg, sl_cp unused.
REQ-012 busy  output  1  operation in progress (RUN).
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 result  output  [0:35]; carry_out  output  1  final result and carry.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-016 IDLE: start=1 at edge -> latch op_s, op_boole, op_a, op_b; carry register <= op_cin; nibble counter <= 8; clear result; go RUN.
REQ-017 RUN: sl_s/sl_boole = latched values; sl_a/sl_b = latched operand bits [4n:4n+3] for counter n; sl_cin = carry register (combinational, stable within cycle).
REQ-018 RUN edge: result[4n:4n+3] <= sl_f; carry register <= sl_cout; counter decrements; at n=0 go DONE.
REQ-019 Carry register updated every RUN cycle regardless of op_boole; carry_out = carry register after nibble 0.
REQ-020 DONE: done=1 for exactly one cycle, busy=0; next state IDLE unconditionally.
REQ-021 Latency: start sampled at edge k -> RUN occupies cycles k+1..k+9 -> done=1 in cycle k+10.
REQ-022 result and carry_out held from DONE until next accepted start; not cleared on abort.
REQ-023 start while busy=1 or during DONE is ignored (no queueing).
REQ-024 Operand inputs may change after acceptance without affecting operation.
REQ-025 abort=1 in RUN -> IDLE at next edge, no done pulse, result/carry_out keep partially written values; abort in IDLE/DONE has no effect (DONE still completes); abort and start same IDLE edge -> abort wins, start dropped.
REQ-026 Slice outputs in IDLE and DONE: sl_s=0000, sl_boole=1, sl_cin=0, sl_a=sl_b=0000.

Reset
REQ-027 reset_n=0 forces immediately: state IDLE, counter 8, busy=0, done=0, result=0, carry_out=0, carry register 0, slice outputs per REQ-026.
REQ-028 Reset mid-RUN discards operation; no done pulse after release; first start after release behaves per REQ-016.

Verification (bench instantiates mc10181 as the slice)
REQ-029 Add: op_s=1001, boole=0, cin=0, A=0o000000000001, B=0o000000000001 -> done at k+10, result=0o000000000002, carry_out=0.
REQ-030 Carry chain wrap: op_s=1001, boole=0, cin=0, A=0o777777777777, B=0o000000000001 -> result=0, carry_out=1; carry visible on sl_cin every RUN cycle after first.
REQ-031 Boolean NOT A: op_s=0000, boole=1, A=0o123456701234, B=0o777777777777 -> result=0o654321076543.
REQ-032 Busy rules: start pulsed at k+3 during RUN -> ignored, single done at k+10; start at k+10 (DONE) ignored; start at k+11 accepted, done at k+21.
REQ-033 Abort: abort at cycle k+5 -> busy=0 at k+6, no done pulse through k+15.
REQ-034 Reset: reset_n low at k+4 -> all outputs at REQ-027 values same cycle; after release, add of REQ-029 completes correctly in 10 cycles.
